ring_shift_sequencer: RTL and testbench

Parametrised successor to the single-bit ring shift register used in the iterative FFT control path. It holds a BITNESS-bit pattern and rotates it left or right by a runtime step of 0..BITNESS-1 positions per beat, with parallel load. A burst mode runs a counted sequence of rotations under a START/BUSY/DONE handshake. It drives stage and butterfly-group one-hot selects without per-stage external counters.

---
 rtl/ring_shift_pkg.sv | 10 +
 rtl/ring_rotate_comb.sv | 18 +
 rtl/ring_shift_sequencer.sv | 98 +++++++++
 tb/tb_ring_shift_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ring_shift_pkg.sv
// ring_shift_pkg: shared state encoding and step helpers for FFT control sequencers
package ring_shift_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int step_w(int bitness);
    return bitness < 2 ? 1 : $clog2(bitness);
  endfunction
  function automatic int eff_step(int step, int bitness);
    return step < bitness ? step : step - bitness;
  endfunction
endpackage

// File: rtl/ring_rotate_comb.sv
// ring_rotate_comb: BITNESS-wide barrel rotator, DIR=1 left, amount s < BITNESS
module ring_rotate_comb #(
  parameter int BITNESS = 16,
  parameter int STEP_W = 4
) (
  input  logic               DIR,
  input  logic [STEP_W-1:0]  s,
  input  logic [BITNESS-1:0] i_DATA,
  output logic [BITNESS-1:0] o_DATA
);
  logic [2*BITNESS-1:0] dd, l, r;
  always_comb begin
    dd = {i_DATA, i_DATA};
    l = dd << s;
    r = dd >> s;
    o_DATA = DIR ? l[2*BITNESS-1:BITNESS] : r[BITNESS-1:0];
  end
endmodule

// File: rtl/ring_shift_sequencer.sv
// ring_shift_sequencer: rotating pattern register with counted burst mode.
// Define RING_SHIFT_POS_EN to build the o_POS/o_WRAP position tracker.
module ring_shift_sequencer
  import ring_shift_pkg::*;
#(
  parameter int BITNESS = 16,
  parameter logic [BITNESS-1:0] RESET_VALUE = BITNESS'(1),
  parameter int STEP_W = step_w(BITNESS),
  parameter int CNT_W = 8
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               EN,
  input  logic               DIR,
  input  logic [STEP_W-1:0]  STEP,
  input  logic               LOAD,
  input  logic [BITNESS-1:0] i_DATA,
  input  logic               START,
  input  logic [CNT_W-1:0]   COUNT,
  output logic [BITNESS-1:0] o_DATA,
  output logic               o_BUSY,
  output logic               o_DONE,
  output logic [STEP_W-1:0]  o_POS,
  output logic               o_WRAP
);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [BITNESS-1:0] data, rot;
  logic [STEP_W-1:0] s_live, ls, rs;
  logic ldir, rdir, start_ok;
  always_comb begin
    s_live = STEP_W'(eff_step(32'(STEP), BITNESS));
    start_ok = START && state == IDLE;
    rdir = state == RUN ? ldir : DIR;
    rs = state == RUN ? ls : s_live;
  end
  ring_rotate_comb #(.BITNESS(BITNESS), .STEP_W(STEP_W)) u_rot (
    .DIR(rdir),
    .s(rs),
    .i_DATA(data),
    .o_DATA(rot)
  );
  always_ff @(posedge CLK)
    if (!RSTn) begin
      state <= IDLE;
      cnt <= '0;
      data <= RESET_VALUE;
      ldir <= 1'b0;
      ls <= '0;
    end else if (LOAD) begin
      state <= IDLE;
      cnt <= '0;
      data <= i_DATA;
    end else if (start_ok) begin
      state <= COUNT == '0 ? DONE : RUN;
      cnt <= COUNT;
      ldir <= DIR;
      ls <= s_live;
    end else if (state == DONE) begin
      state <= IDLE;
    end else if (EN) begin
      data <= rot;
      if (state == RUN) begin
        cnt <= cnt - 1'b1;
        state <= cnt == CNT_W'(1) ? DONE : RUN;
      end
    end
  assign o_DATA = data;
  assign o_BUSY = state == RUN;
  assign o_DONE = state == DONE;
`ifdef RING_SHIFT_POS_EN
  localparam logic [STEP_W:0] B = (STEP_W+1)'(BITNESS);
  logic beat, wc, wrap;
  logic [STEP_W:0] sum, dif;
  logic [STEP_W-1:0] pos, nxt;
  // dif is pos-s biased by +BITNESS so the wrapped right case needs no extra subtract
  always_comb begin
    beat = EN && !LOAD && !start_ok && state != DONE;
    sum = {1'b0, pos} + {1'b0, rs};
    dif = {1'b0, pos} + B - {1'b0, rs};
    wc = rdir ? sum >= B : pos < rs;
    nxt = STEP_W'(rdir ? (wc ? sum - B : sum) : (wc ? dif : dif - B));
  end
  always_ff @(posedge CLK)
    if (!RSTn || LOAD) begin
      pos <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= beat && wc;
      if (beat) pos <= nxt;
    end
  assign o_POS = pos;
  assign o_WRAP = wrap;
`else
  assign o_POS = '0;
  assign o_WRAP = 1'b0;
`endif
endmodule

// File: tb/tb_ring_shift_sequencer.sv
// tb_ring_shift_sequencer: model-checked directed test of ring_shift_sequencer (8- and 12-bit instances)
module tb_ring_shift_sequencer;
`ifdef RING_SHIFT_POS_EN
  localparam bit POS_ON = 1'b1;
`else
  localparam bit POS_ON = 1'b0;
`endif
  logic clk = 1'b0, rstn = 1'b0;
  logic en = 0, dir = 0, load = 0, start = 0;
  logic [2:0] step = 0;
  logic [7:0] i_data = 0, count = 0;
  logic [7:0] o_data;
  logic o_busy, o_done, o_wrap;
  logic [2:0] o_pos;
  logic en12 = 0, dir12 = 0;
  logic [3:0] step12 = 0;
  logic [11:0] o_data12;
  logic o_busy12, o_done12, o_wrap12;
  logic [3:0] o_pos12;
  int n_cmp = 0, n_bad = 0;
  bit chk = 0;
  int busy_n, done_n, wrap_n;

  always #5 clk = ~clk;

  ring_shift_sequencer #(.BITNESS(8), .RESET_VALUE(8'h01)) dut (
    .CLK(clk), .RSTn(rstn), .EN(en), .DIR(dir), .STEP(step), .LOAD(load),
    .i_DATA(i_data), .START(start), .COUNT(count), .o_DATA(o_data),
    .o_BUSY(o_busy), .o_DONE(o_done), .o_POS(o_pos), .o_WRAP(o_wrap)
  );
  ring_shift_sequencer #(.BITNESS(12), .RESET_VALUE(12'h001)) dut12 (
    .CLK(clk), .RSTn(rstn), .EN(en12), .DIR(dir12), .STEP(step12), .LOAD(1'b0),
    .i_DATA(12'h000), .START(1'b0), .COUNT(8'd0), .o_DATA(o_data12),
    .o_BUSY(o_busy12), .o_DONE(o_done12), .o_POS(o_pos12), .o_WRAP(o_wrap12)
  );

  typedef struct packed {
    logic [7:0] data;
    int pos;
    logic wrap, busy, done, ldir;
    int ls;
    int left;
  } mst_t;
  mst_t m = '0;

  // Reference: rotation as bit relocation, position as signed integer sum mod 8
  function automatic mst_t mnext(mst_t c);
    mst_t n = c;
    bit l;
    int s, t;
    n.wrap = 1'b0;
    if (!rstn) begin
      n = '0;
      n.data = 8'h01;
    end else if (load) begin
      n.data = i_data; n.pos = 0; n.busy = 0; n.done = 0; n.left = 0;
    end else if (c.done) begin
      n.done = 0;
    end else if (start && !c.busy) begin
      n.ldir = dir; n.ls = int'(step) % 8; n.left = int'(count);
      if (count == 0) n.done = 1; else n.busy = 1;
    end else if (en) begin
      l = c.busy ? c.ldir : dir;
      s = c.busy ? c.ls : int'(step) % 8;
      for (int i = 0; i < 8; i++) n.data[l ? (i + s) % 8 : (i - s + 8) % 8] = c.data[i];
      t = c.pos + (l ? s : -s);
      n.wrap = l ? t >= 8 : t < 0;
      n.pos = (t + 8) % 8;
      if (c.busy) begin
        n.left = n.left - 1;
        if (n.left == 0) begin n.busy = 0; n.done = 1; end
      end
    end
    return n;
  endfunction

  always @(posedge clk) m <= mnext(m);

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (chk) begin
      cmp("m_data", 32'(o_data), 32'(m.data));
      cmp("m_busy", 32'(o_busy), 32'(m.busy));
      cmp("m_done", 32'(o_done), 32'(m.done));
      cmp("m_pos", 32'(o_pos), POS_ON ? 32'(m.pos) : 32'd0);
      cmp("m_wrap", 32'(o_wrap), POS_ON ? 32'(m.wrap) : 32'd0);
    end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic acc;
    busy_n += int'(o_busy);
    done_n += int'(o_done);
    wrap_n += int'(o_wrap);
  endtask

  initial begin
    tick();
    chk = 1;
    tick();
    cmp("rst_data", 32'(o_data), 32'h01);
    cmp("rst_pos", 32'(o_pos), 0);
    cmp("rst_busy", 32'(o_busy), 0);
    cmp("rst_done", 32'(o_done), 0);
    cmp("rst_wrap", 32'(o_wrap), 0);
    rstn = 1;
    dir12 = 0; step12 = 4'd13; en12 = 1;
    tick();
    en12 = 0;
    cmp("b12_data", 32'(o_data12), 32'h800);
    cmp("b12_pos", 32'(o_pos12), POS_ON ? 32'd11 : 32'd0);
    cmp("b12_wrap", 32'(o_wrap12), 32'(POS_ON));
    dir = 1; step = 3; en = 1;
    tick();
    cmp("idle1_data", 32'(o_data), 32'h08);
    cmp("idle1_pos", 32'(o_pos), POS_ON ? 32'd3 : 32'd0);
    cmp("idle1_wrap", 32'(o_wrap), 0);
    tick();
    cmp("idle2_data", 32'(o_data), 32'h40);
    cmp("idle2_pos", 32'(o_pos), POS_ON ? 32'd6 : 32'd0);
    cmp("idle2_wrap", 32'(o_wrap), 0);
    tick();
    cmp("idle3_data", 32'(o_data), 32'h02);
    cmp("idle3_pos", 32'(o_pos), POS_ON ? 32'd1 : 32'd0);
    cmp("idle3_wrap", 32'(o_wrap), 32'(POS_ON));
    en = 0; load = 1; i_data = 8'h01;
    tick();
    load = 0;
    busy_n = 0; done_n = 0; wrap_n = 0;
    start = 1; count = 4; dir = 1; step = 2; en = 1;
    tick();
    acc();
    start = 0; dir = 0; step = 5;
    for (int i = 0; i < 6; i++) begin
      en = i != 1;
      tick();
      acc();
    end
    en = 0;
    cmp("burst_busy_cycles", 32'(busy_n), 5);
    cmp("burst_done_pulses", 32'(done_n), 1);
    cmp("burst_wrap_pulses", 32'(wrap_n), POS_ON ? 32'd1 : 32'd0);
    cmp("burst_data", 32'(o_data), 32'h01);
    start = 1; count = 5; dir = 1; step = 1; en = 1;
    tick();
    start = 0;
    tick();
    load = 1; i_data = 8'h81;
    tick();
    load = 0; en = 0;
    cmp("abort_data", 32'(o_data), 32'h81);
    cmp("abort_pos", 32'(o_pos), 0);
    cmp("abort_busy", 32'(o_busy), 0);
    done_n = 0;
    for (int i = 0; i < 3; i++) begin tick(); acc(); end
    cmp("abort_no_done", 32'(done_n), 0);
    start = 1; count = 0;
    tick();
    cmp("c0_done", 32'(o_done), 1);
    cmp("c0_busy", 32'(o_busy), 0);
    cmp("c0_data", 32'(o_data), 32'h81);
    tick();
    cmp("c0_start_in_done_ignored", 32'(o_done), 0);
    tick();
    cmp("c0_b2b_done", 32'(o_done), 1);
    count = 2; dir = 0; step = 7; en = 1;
    tick();
    tick();
    start = 0;
    tick();
    tick();
    cmp("b2b_data", 32'(o_data), 32'h06);
    cmp("b2b_pos", 32'(o_pos), POS_ON ? 32'd2 : 32'd0);
    cmp("b2b_done", 32'(o_done), 1);
    en = 0;
    tick();
    dir = 1; step = 0; en = 1;
    tick();
    cmp("s0_data", 32'(o_data), 32'h06);
    cmp("s0_wrap", 32'(o_wrap), 0);
    start = 1; count = 5; step = 1;
    tick();
    start = 0;
    tick();
    tick();
    rstn = 0;
    tick();
    cmp("midrst_data", 32'(o_data), 32'h01);
    cmp("midrst_busy", 32'(o_busy), 0);
    cmp("midrst_pos", 32'(o_pos), 0);
    rstn = 1; en = 0;
    done_n = 0;
    for (int i = 0; i < 2; i++) begin tick(); acc(); end
    cmp("midrst_no_done", 32'(done_n), 0);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
